// File: rtl/plab4_net_router_output_sched_tdm.sv
// -----------------------------------------------------------------------------
// plab4_net_router_output_sched_tdm
//
// Output-port scheduler for one router output fed by three input ports. The
// port is time-partitioned between two security domains (0 = low, 1 = high)
// in fixed alternating epochs of EPOCH_LEN cycles. Within an epoch only
// requesters of the current domain are arbitrated (round robin). A grant is
// locked to its winner for the whole multi-flit packet.
//
// Handshake: a flit moves when out_val and out_rdy are both high in the same
// cycle. out_val is a pure function of the requests and the scheduler state;
// it never depends on out_rdy. A low out_rdy simply stalls the flit, and in
// IDLE the winner may change on the next cycle.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqs_p0..p2                 port i has a flit for this output
//   reqs_p0..p2_domain          security domain of port i traffic
//   tail_p0..p2                 port i current flit is the packet tail
//   grants_p0..p2               port i granted this cycle (at most one)
//   out_val / out_rdy           output flit valid / downstream ready
//   xbar_sel                    crossbar select (granted port, owner in BUSY)
//   out_domain                  domain of the current epoch
//   overrun                     sticky: a packet ran past an epoch boundary
//   dbg_state_o                 scheduler state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module plab4_net_router_output_sched_tdm #(
  parameter int EPOCH_LEN   = 16,
  parameter int MAX_PKT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqs_p0,
  input  logic       reqs_p1,
  input  logic       reqs_p2,
  input  logic       reqs_p0_domain,
  input  logic       reqs_p1_domain,
  input  logic       reqs_p2_domain,
  input  logic       tail_p0,
  input  logic       tail_p1,
  input  logic       tail_p2,
  output logic       grants_p0,
  output logic       grants_p1,
  output logic       grants_p2,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [1:0] xbar_sel,
  output logic       out_domain,
  output logic       overrun,
  output logic       dbg_state_o
);

  localparam int CW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(EPOCH_LEN - 1);
  // A packet may start only while EPOCH_LEN - cnt >= MAX_PKT_LEN,
  // i.e. cnt <= EPOCH_LEN - MAX_PKT_LEN.
  localparam logic [CW-1:0] START_MAX = CW'(EPOCH_LEN - MAX_PKT_LEN);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q,        state_d;
  logic [CW-1:0]   epoch_cnt_q,    epoch_cnt_d;
  logic            epoch_domain_q, epoch_domain_d;
  logic [1:0]      rr_ptr_q,       rr_ptr_d;
  logic [1:0]      owner_q,        owner_d;
  logic            overrun_q,      overrun_d;

  logic [2:0] req_v, dom_v, tail_v, elig_v, gnt_v;
  logic [1:0] cand1, cand2, cand3, win, sel;
  logic       any_elig, start_ok, xfer, tail_x, at_last, hold;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    inc3 = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    bit_at = v[0];
      2'd1:    bit_at = v[1];
      default: bit_at = v[2];
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      default: onehot = 3'b100;
    endcase
  endfunction

  assign req_v  = {reqs_p2, reqs_p1, reqs_p0};
  assign dom_v  = {reqs_p2_domain, reqs_p1_domain, reqs_p0_domain};
  assign tail_v = {tail_p2, tail_p1, tail_p0};

  // Only traffic of the current epoch's domain may compete.
  assign elig_v   = req_v & ~(dom_v ^ {3{epoch_domain_q}});
  assign start_ok = (epoch_cnt_q <= START_MAX);

  // Search order after the last winner: rr+1, rr+2, rr (mod 3).
  assign cand1 = inc3(rr_ptr_q);
  assign cand2 = inc3(cand1);
  assign cand3 = rr_ptr_q;

  always_comb begin
    win      = cand3;
    any_elig = 1'b0;
    if (bit_at(elig_v, cand1)) begin
      win      = cand1;
      any_elig = 1'b1;
    end else if (bit_at(elig_v, cand2)) begin
      win      = cand2;
      any_elig = 1'b1;
    end else if (bit_at(elig_v, cand3)) begin
      win      = cand3;
      any_elig = 1'b1;
    end
  end

  // Grant / select. While locked, the owner keeps the crossbar regardless of
  // domain or start guard; nobody else is granted. Reset masks every grant
  // so nothing is issued in the reset cycle itself.
  always_comb begin
    gnt_v = '0;
    sel   = '0;
    if (!reset) begin
      if (state_q == BUSY) begin
        sel   = owner_q;
        gnt_v = onehot(owner_q) & {3{bit_at(req_v, owner_q)}};
      end else if (start_ok && any_elig) begin
        sel   = win;
        gnt_v = onehot(win);
      end
    end
  end

  assign out_val = |gnt_v;
  assign xfer    = out_val & out_rdy;
  assign tail_x  = bit_at(tail_v, sel);
  assign at_last = (epoch_cnt_q == LAST_CNT);
  // A locked packet that has not finished by the last epoch cycle stretches
  // the epoch: the counter parks on its last value until the tail moves.
  assign hold    = (state_q == BUSY) && at_last && !(xfer && tail_x);

  // Packet lock FSM and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (tail_x) begin
        state_d  = IDLE;
        rr_ptr_d = sel;
      end else begin
        state_d  = BUSY;
        owner_d  = sel;
      end
    end
  end

  // Epoch counter and domain toggle.
  always_comb begin
    epoch_cnt_d    = epoch_cnt_q + 1'b1;
    epoch_domain_d = epoch_domain_q;
    overrun_d      = overrun_q;
    if (hold) begin
      epoch_cnt_d = epoch_cnt_q;
      overrun_d   = 1'b1;
    end else if (at_last) begin
      epoch_cnt_d    = '0;
      epoch_domain_d = ~epoch_domain_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      epoch_cnt_q    <= '0;
      epoch_domain_q <= 1'b0;
      rr_ptr_q       <= 2'd2;
      owner_q        <= 2'd0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      epoch_cnt_q    <= epoch_cnt_d;
      epoch_domain_q <= epoch_domain_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      overrun_q      <= overrun_d;
    end
  end

  assign grants_p0   = gnt_v[0];
  assign grants_p1   = gnt_v[1];
  assign grants_p2   = gnt_v[2];
  assign xbar_sel    = sel;
  assign out_domain  = epoch_domain_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_plab4_net_router_output_sched_tdm.sv
// -----------------------------------------------------------------------------
// Testbench for plab4_net_router_output_sched_tdm.
// Inputs change 1 time unit after the rising edge; the reference model is
// compared against the DUT on every falling edge, and directed literal
// checks are taken 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_plab4_net_router_output_sched_tdm;

  localparam int EPOCH_LEN   = 16;
  localparam int MAX_PKT_LEN = 4;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [2:0] req     = '0;
  logic [2:0] dom     = '0;
  logic [2:0] tail    = '0;
  logic       out_rdy = 1'b1;

  logic       grants_p0, grants_p1, grants_p2, out_val, out_domain, overrun, dbg_state;
  logic [1:0] xbar_sel;
  logic [2:0] gnts;

  always #5 clk = ~clk;

  plab4_net_router_output_sched_tdm #(
    .EPOCH_LEN   (EPOCH_LEN),
    .MAX_PKT_LEN (MAX_PKT_LEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .reqs_p0        (req[0]),
    .reqs_p1        (req[1]),
    .reqs_p2        (req[2]),
    .reqs_p0_domain (dom[0]),
    .reqs_p1_domain (dom[1]),
    .reqs_p2_domain (dom[2]),
    .tail_p0        (tail[0]),
    .tail_p1        (tail[1]),
    .tail_p2        (tail[2]),
    .grants_p0      (grants_p0),
    .grants_p1      (grants_p1),
    .grants_p2      (grants_p2),
    .out_val        (out_val),
    .out_rdy        (out_rdy),
    .xbar_sel       (xbar_sel),
    .out_domain     (out_domain),
    .overrun        (overrun),
    .dbg_state_o    (dbg_state)
  );

  assign gnts = {grants_p2, grants_p1, grants_p0};

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract state: position in the epoch, epoch domain, whether a packet
  // owns the port (and which), last tail winner, sticky overrun.
  int m_cnt, m_dom, m_locked, m_owner, m_rr, m_ovr;
  int e_sel, e_idx;
  bit e_any, e_xfer, e_tl;
  logic [2:0] e_gnt;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_grants", gnts, 0);
      chk("rst_out_val", out_val, 0);
      chk("rst_xbar_sel", xbar_sel, 0);
      chk("rst_out_domain", out_domain, 0);
      chk("rst_overrun", overrun, 0);
      m_cnt = 0; m_dom = 0; m_locked = 0; m_owner = 0; m_rr = 2; m_ovr = 0;
    end else begin
      e_gnt = '0;
      e_sel = 0;
      e_any = 0;
      if (m_locked != 0) begin
        e_sel = m_owner;
        e_gnt[m_owner] = req[m_owner];
      end else if (EPOCH_LEN - m_cnt >= MAX_PKT_LEN) begin
        for (int k = 1; k <= 3; k++) begin
          e_idx = (m_rr + k) % 3;
          if (!e_any && req[e_idx] && (int'(dom[e_idx]) == m_dom)) begin
            e_any = 1;
            e_sel = e_idx;
            e_gnt[e_idx] = 1'b1;
          end
        end
      end
      chk("grants", gnts, e_gnt);
      chk("out_val", out_val, (e_gnt != 0));
      chk("xbar_sel", xbar_sel, e_sel);
      chk("out_domain", out_domain, m_dom);
      chk("overrun", overrun, m_ovr);

      // advance to the state seen after the coming rising edge
      e_xfer = (e_gnt != 0) && out_rdy;
      e_tl   = tail[e_sel];
      if ((m_locked != 0) && m_cnt == EPOCH_LEN - 1 && !(e_xfer && e_tl)) begin
        m_ovr = 1;
      end else if (m_cnt == EPOCH_LEN - 1) begin
        m_cnt = 0;
        m_dom = 1 - m_dom;
      end else begin
        m_cnt++;
      end
      if (e_xfer) begin
        if (e_tl) begin
          m_locked = 0;
          m_rr     = e_sel;
        end else begin
          m_locked = 1;
          m_owner  = e_sel;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    dom     = '0;
    tail    = '0;
    out_rdy = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int exp_sel[4] = '{0, 1, 2, 0};
  int rdy_v[6]   = '{1, 1, 0, 0, 1, 1};
  int tl_v[6]    = '{0, 0, 0, 0, 0, 1};
  int first;

  initial begin
    // round robin among three single-flit requesters
    do_reset();
    req = 3'b111; dom = 3'b000; tail = 3'b111; out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("t1_sel", xbar_sel, exp_sel[c]);
      chk("t1_gnt", gnts, 3'b001 << exp_sel[c]);
      nxt();
    end

    // domain-1 requester waits for the domain-1 epoch
    do_reset();
    req = 3'b010; dom = 3'b010; tail = 3'b111;
    first = -1;
    for (int c = 0; c < 40 && first < 0; c++) begin
      mid();
      if (out_val) begin
        first = c;
        chk("t2_domain", out_domain, 1);
        chk("t2_gnt", gnts, 3'b010);
      end
      nxt();
    end
    chk("t2_first_cycle", first, 16);

    // 3-flit packet from p0 locks out p2
    do_reset();
    req = 3'b101; dom = 3'b000; tail = 3'b100;
    for (int c = 0; c < 4; c++) begin
      tail[0] = (c == 2);
      mid();
      if (c < 3) chk("t3_lock_p0", gnts, 3'b001);
      else       chk("t3_then_p2", gnts, 3'b100);
      nxt();
    end
    req = '0; tail = '0;

    // 4-flit packet at cnt 12 with a 2-cycle stall runs over the boundary
    do_reset();
    repeat (12) nxt();
    req = 3'b001; dom = 3'b000;
    for (int c = 0; c < 6; c++) begin
      out_rdy = rdy_v[c][0];
      tail[0] = tl_v[c][0];
      mid();
      chk("t4_gnt", gnts, 3'b001);
      if (c == 3) chk("t4_ovr_pre", overrun, 0);
      if (c >= 4) begin
        chk("t4_ovr", overrun, 1);
        chk("t4_dom_held", out_domain, 0);
      end
      nxt();
    end
    req = '0; tail = '0; out_rdy = 1'b1;
    mid();
    chk("t4_dom_toggled", out_domain, 1);
    chk("t4_ovr_sticky", overrun, 1);
    nxt();

    // request too late in the epoch waits for the next domain-0 epoch
    do_reset();
    repeat (13) nxt();
    req = 3'b001; dom = 3'b000; tail = 3'b001;
    first = -1;
    for (int c = 13; c < 60 && first < 0; c++) begin
      mid();
      if (out_val) begin
        first = c;
        chk("t5_domain", out_domain, 0);
      end
      nxt();
    end
    chk("t5_first_cycle", first, 32);
    req = '0;

    // reset in the middle of a packet
    do_reset();
    req = 3'b011; dom = 3'b000; tail = 3'b010;
    nxt();
    chk("t6_busy_flit2", gnts, 3'b001);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_gnt", gnts, 0);
    chk("t6_rst_val", out_val, 0);
    nxt();
    reset = 1'b0;
    tail  = 3'b011;
    mid();
    chk("t6_p0_first", gnts, 3'b001);
    chk("t6_sel", xbar_sel, 0);
    nxt();

    // mixed traffic, checked by the model only
    do_reset();
    for (int c = 0; c < 200; c++) begin
      req     = 3'($urandom_range(0, 7));
      dom     = (c % 50 < 25) ? 3'b000 : 3'($urandom_range(0, 7));
      tail    = 3'($urandom_range(0, 7));
      out_rdy = ($urandom_range(0, 3) != 0);
      nxt();
    end
    req = '0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/plab4_net_router_output_sched_tdm.md
Name: plab4_net_router_output_sched_tdm

Overview:
Output-port scheduler for one router output with three input ports. It time-partitions the port between two security domains (0 = low, 1 = high) in fixed alternating epochs. Within an epoch, it round-robin arbitrates only among requesters whose domain matches the current epoch, and it locks the grant for a whole multi-flit packet. It drives the crossbar select and output valid, and replaces the free-running arbiter-based output control on domain-isolated routers.

Parameters:
EPOCH_LEN, 16, cycles per domain epoch; legal range is at least MAX_PKT_LEN.
MAX_PKT_LEN, 4, maximum flits per packet; used as the start-of-packet guard.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
reqs_p0  input  1  port 0 has a flit for this output
reqs_p1  input  1  port 1 has a flit for this output
reqs_p2  input  1  port 2 has a flit for this output
reqs_p0_domain  input  1  security domain of port 0 traffic
reqs_p1_domain  input  1  security domain of port 1 traffic
reqs_p2_domain  input  1  security domain of port 2 traffic
tail_p0  input  1  port 0 current flit is the packet tail
tail_p1  input  1  port 1 current flit is the packet tail
tail_p2  input  1  port 2 current flit is the packet tail
grants_p0  output  1  port 0 granted this cycle
grants_p1  output  1  port 1 granted this cycle
grants_p2  output  1  port 2 granted this cycle
out_val  output  1  output flit valid
out_rdy  input  1  downstream ready
xbar_sel  output  2  crossbar select (0, 1 or 2)
out_domain  output  1  domain of the current epoch
overrun  output  1  sticky flag: a packet crossed an epoch boundary

Behaviour:
- Reset (asynchronous) values:
  - epoch_cnt = 0, epoch_domain = 0, state = IDLE.
  - rr_ptr = 2, so p0 has highest priority first.
  - overrun = 0.
  - All grants = 0, out_val = 0, xbar_sel = 0, out_domain = 0.
- Epoch counter:
  - Increments every cycle.
  - At EPOCH_LEN-1 it wraps to 0 and toggles epoch_domain.
  - Exception: in BUSY at EPOCH_LEN-1 without a tail transfer, the counter holds and the domain does not toggle, and overrun is set.
  - The toggle resumes on the cycle after the tail transfer.
- out_domain = epoch_domain.
- Eligibility: port i is eligible when reqs_pi = 1 and reqs_pi_domain = epoch_domain.
- Start guard (IDLE only): a new packet may start only if remaining = EPOCH_LEN - epoch_cnt is at least MAX_PKT_LEN. Otherwise no grant is issued.
- IDLE state:
  - Pick the first eligible port in the order rr_ptr+1, rr_ptr+2, rr_ptr (mod 3), and assert its grant combinationally.
  - A transfer occurs when out_val and out_rdy are both 1.
  - Transfer with tail = 1: stay IDLE and set rr_ptr = winner.
  - Transfer with tail = 0: go to BUSY with owner = winner.
  - No transfer (out_rdy = 0): stay IDLE; re-arbitrate next cycle, and the winner may change.
- BUSY state:
  - grants_powner = reqs_powner. Domain and start guard are ignored while locked; other ports are never granted.
  - Transfer with tail = 1: go to IDLE and set rr_ptr = owner.
  - A flit without tail keeps BUSY.
- Output signals:
  - out_val = OR of all grants.
  - xbar_sel = index of the granted port, or the owner in BUSY; it is 0 when nothing is granted.
  - At most one grant is asserted in any cycle.
- rr_ptr changes only on a tail transfer.
- Simultaneous events: a tail transfer on the epoch's last cycle completes normally and the epoch toggles that same edge.
- Reset mid-packet: the lock is dropped immediately and reset values apply; no grant is issued in the reset cycle.

Test Plan:
- Reset, then reqs_p0 = reqs_p1 = reqs_p2 = 1, all domains 0, tail = 1, out_rdy = 1 → grants in order p0, p1, p2, p0 on cycles 0-3; xbar_sel = 0, 1, 2, 0.
- p1 domain 1 only, requesting from reset → no grant for cycles 0-15; first grant at cycle 16 with out_domain = 1.
- p0 sends a 3-flit packet (tail on flit 3) while p2 also requests → grants_p0 is held for 3 transfers and p2 is not granted until the cycle after the tail.
- p0 starts a 4-flit packet at epoch_cnt = 12 and out_rdy drops for 2 cycles → the counter holds at 15 and overrun = 1; the domain toggles the cycle after the tail.
- A request arriving at epoch_cnt = 13 with MAX_PKT_LEN = 4 → no grant through cycle 15; in the next same-domain epoch it is granted at cnt = 0.
- Assert reset while BUSY at flit 2 → all outputs 0 immediately; after release, p0 wins first (rr_ptr = 2).
